// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one fixed-latency parallel FP32 multiplier among NUM_REQ
// requesters; a tag pipeline routes each result back to its owner as a one-cycle pulse.
module mult_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LANES    = 4,
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 5,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(MULT_LAT + 2)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ-1:0][LANES-1:0][DATA_W-1:0] req_opa,
    input  logic [NUM_REQ-1:0][LANES-1:0][DATA_W-1:0] req_opb,
    output logic [LANES-1:0][DATA_W-1:0]              mult_opa,
    output logic [LANES-1:0][DATA_W-1:0]              mult_opb,
    input  logic [LANES-1:0][DATA_W-1:0]              mult_out,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    output logic [LANES-1:0][DATA_W-1:0]              rsp_data,
    output logic [CNT_W-1:0]                          inflight,
    output logic                                      busy
);

    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                hs;
    logic [MULT_LAT-1:0] vld_p;
    logic [ID_W-1:0]     id_p [MULT_LAT];
    logic [NUM_REQ-1:0]  rsp_onehot;

    // Modular increment of a requester index, used for both the scan and the pointer update.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant == '0 && req_valid[wrap_add(rr_ptr, k)]) begin
                    grant[wrap_add(rr_ptr, k)] = 1'b1;
                    grant_id                   = wrap_add(rr_ptr, k);
                end
            end
        end
    end

    assign hs        = |grant;
    assign req_ready = grant;
    assign mult_opa  = hs ? req_opa[grant_id] : '0;
    assign mult_opb  = hs ? req_opb[grant_id] : '0;
    assign busy      = (inflight != '0);

    always_comb begin
        rsp_onehot = '0;
        if (vld_p[MULT_LAT-1]) rsp_onehot[id_p[MULT_LAT-1]] = 1'b1;
    end

    // Stage p0 captures the issue tag; stage MULT_LAT-1 lines up with mult_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            vld_p     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
        end else begin
            if (hs) rr_ptr <= wrap_add(grant_id, 1);
            vld_p[0] <= hs;
            for (int k = 1; k < MULT_LAT; k++) vld_p[k] <= vld_p[k-1];
            rsp_valid <= rsp_onehot;
            if (vld_p[MULT_LAT-1]) rsp_data <= mult_out;
            case ({hs, |rsp_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Owner ids need no reset: they are qualified by vld_p.
    always_ff @(posedge clk) begin
        id_p[0] <= grant_id;
        for (int k = 1; k < MULT_LAT; k++) id_p[k] <= id_p[k-1];
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural FP32 multiplier plus a scoreboard of
// expected owner, data and latency for every issued op.
module tb_mult_share_arbiter;

    localparam int NR  = 4;
    localparam int LN  = 4;
    localparam int DW  = 32;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0]               req_valid = '0;
    logic [NR-1:0]               req_ready;
    logic [NR-1:0][LN-1:0][DW-1:0] req_opa = '0;
    logic [NR-1:0][LN-1:0][DW-1:0] req_opb = '0;
    logic [LN-1:0][DW-1:0]       mult_opa, mult_opb, mult_out;
    logic [NR-1:0]               rsp_valid;
    logic [LN-1:0][DW-1:0]       rsp_data;
    logic [2:0]                  inflight;
    logic                        busy;

    mult_share_arbiter #(.NUM_REQ(NR), .LANES(LN), .DATA_W(DW), .MULT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .mult_opa(mult_opa), .mult_opb(mult_opb),
        .mult_out(mult_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Multiplier model for normal/zero operands, truncating; exact for the values used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int e;
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) return {a[31] ^ b[31], 8'(e + 1), m[46:24]};
        return {a[31] ^ b[31], 8'(e), m[45:23]};
    endfunction

    logic [LN-1:0][DW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        for (int j = 0; j < LN; j++) mpipe[0][j] <= fmul(mult_opa[j], mult_opb[j]);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_out = mpipe[LAT-1];

    typedef struct packed {
        logic [1:0]            id;
        logic [31:0]           cyc;
        logic [LN-1:0][DW-1:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t me;
    logic [1:0] mid;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rdy_onehot", 128'($onehot0(req_ready)), 128'd1);
            chk("rdy_subset", req_ready & ~req_valid, 0);
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    me = sbq.pop_front();
                    chk("rsp_owner", rsp_valid, 4'b0001 << me.id);
                    chk("rsp_data", rsp_data, me.data);
                    chk("rsp_latency", 32'(cyc) - me.cyc, LAT + 1);
                end
            end
            if (sbq.size() > 0 && 32'(cyc) - sbq[0].cyc > LAT + 1) begin
                chk("rsp_missing", cyc, sbq[0].cyc + LAT + 1);
                void'(sbq.pop_front());
            end
            chk("busy_vs_inflight", busy, inflight != 3'd0);
            if (rst) sbq.delete();
            else if (|(req_valid & req_ready)) begin
                mid = 2'd0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) mid = 2'(i);
                me.id  = mid;
                me.cyc = cyc;
                for (int j = 0; j < LN; j++) me.data[j] = fmul(req_opa[mid][j], req_opb[mid][j]);
                chk("issue_opa", mult_opa, req_opa[mid]);
                chk("issue_opb", mult_opb, req_opb[mid]);
                sbq.push_back(me);
            end else begin
                chk("idle_opa", mult_opa, 0);
                chk("idle_opb", mult_opb, 0);
            end
        end
    end

    logic [31:0] fv [4];
    logic [31:0] v3 [6];
    logic [31:0] p3 [6];

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("rst_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'h0;
    endtask

    initial begin
        fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        v3 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        p3 = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

        // Reset state
        rst = 1'b1;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        mon_en = 1'b1;

        // Idle: operands present but nothing valid
        for (int i = 0; i < NR; i++) for (int j = 0; j < LN; j++) begin
            req_opa[i][j] = 32'h3F800000;
            req_opb[i][j] = 32'h40000000;
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_rsp", rsp_valid, 0);
        end

        // Single op from requester 1, lane 1: 5.0 * 4.0
        @(posedge clk); #1;
        req_opa = '0;
        req_opb = '0;
        req_opa[1][1] = 32'h40A00000;
        req_opb[1][1] = 32'h40800000;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("single_grant", req_ready, 4'b0010);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            req_valid = 4'b0000;
            @(negedge clk);
            if (k == LAT + 1) begin
                chk("single_pulse", rsp_valid, 4'b0010);
                chk("single_data", rsp_data, 128'h00000000_00000000_41A00000_00000000);
            end else chk("single_no_pulse", rsp_valid, 0);
        end

        // All requesters valid for 8 cycles, starting from a fresh pointer
        do_reset();
        for (int i = 0; i < NR; i++) for (int j = 0; j < LN; j++) begin
            req_opa[i][j] = fv[i];
            req_opb[i][j] = fv[j];
        end
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (k < 8) chk("rr_order", req_ready, 4'b0001 << (k % 4));
        end

        // Lone requester 2 streams six ops without bubbles
        req_opb[2][0] = 32'h40000000;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k < 6) begin
                req_valid = 4'b0100;
                req_opa[2][0] = v3[k];
            end else req_valid = 4'b0000;
            @(negedge clk);
            if (k < 6) chk("lone_grant", req_ready, 4'b0100);
            else begin
                chk("lone_pulse", rsp_valid, 4'b0100);
                chk("lone_lane0", rsp_data[0], p3[k-6]);
            end
        end

        // Steady stream from requester 0: issue and retire every cycle
        for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 15) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (k >= LAT + 1 && k < 15) chk("steady_inflight", inflight, LAT + 1);
            if (k == 20) begin
                chk("last_pulse", rsp_valid, 4'b0001);
                chk("busy_at_last", busy, 1);
            end
            if (k == 21) begin
                chk("busy_after_last", busy, 0);
                chk("no_pulse_after_last", rsp_valid, 0);
            end
        end

        // Reset with three ops in flight
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            rst = (k == 3);
            if (k < 3) req_valid = 4'b0110;
            else if (k == 3) req_valid = 4'hF;
            else if (k == 14) req_valid = 4'hF;
            else req_valid = 4'h0;
            @(negedge clk);
            if (k == 3) chk("midrst_ready_low", req_ready, 0);
            if (k == 4) begin
                chk("midrst_inflight", inflight, 0);
                chk("midrst_busy", busy, 0);
            end
            if (k >= 4 && k < 14) chk("midrst_no_pulse", rsp_valid, 0);
            if (k == 14) chk("midrst_ptr_zero", req_ready, 4'b0001);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            req_valid = 4'h0;
            @(negedge clk);
        end
        chk("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
